acc_mc_controller: RTL
======================

ACC_MC_CONTROLLER -- requirements
Module: acc_mc_controller

Interface
REQ-001 SHALL have parameter OPW, default 4, opcode width (legal values >= 4).
REQ-002 SHALL have parameter ALUW, default 3, ALU command width (legal values >= 3).
REQ-003 SHALL have port clk  in  1  single system clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port upcode  in  OPW  opcode from IR, stable from DECODE until the instruction completes.
REQ-006 SHALL have port mem_ready  in  1  memory handshake, high = current read/write completes this cycle.
REQ-007 SHALL have port acZero  in  1  accumulator equals zero.
REQ-008 SHALL have ports pcWrite, pcSrc, memAddressSel, ACdataSel, memRead, memWrite, irWrite, ACwrite, ACread  out  1 each  datapath controls.
REQ-009 SHALL have ports ALUcommand out ALUW; halted out 1; illegal out 1 (one-cycle pulse).

Function
REQ-010 SHALL be a Moore FSM with states IDLE, FETCH, DECODE, MEMRD, MEMWR, WB, JUMP, HALT; outputs depend on state, mem_ready and latched opcode only.
REQ-011 SHALL decode: 0 LDA, 1 STA, 2 ADD, 3 SUB, 4 AND, 5 NOT, 6 JMP, 7 JZ, 8 NOP, 15 HLT; all other values (including upper OPW range) illegal.
REQ-012 SHALL encode ALUcommand: ADD=0, SUB=1, AND=2, NOT=3, PASS=4, zero-extended to ALUW; PASS outside WB.
REQ-013 IDLE: all outputs 0; next state FETCH unconditionally.
REQ-014 FETCH: memAddressSel=0, memRead=1; when mem_ready=1 also irWrite=1, pcWrite=1, pcSrc=0, next DECODE; else hold FETCH.
REQ-015 DECODE: all outputs 0; next: LDA/ADD/SUB/AND->MEMRD, STA->MEMWR, NOT->WB, JMP->JUMP, JZ->JUMP if acZero=1 else FETCH, NOP->FETCH, HLT->HALT, illegal->FETCH with illegal=1 this cycle.
REQ-016 MEMRD: memAddressSel=1, memRead=1; hold until mem_ready=1, then WB.
REQ-017 MEMWR: memAddressSel=1, memWrite=1, ACread=1; hold until mem_ready=1, then FETCH.
REQ-018 WB: ACwrite=1; LDA: ACdataSel=0, ALUcommand=PASS; ADD/SUB/AND/NOT: ACdataSel=1, ACread=1, ALUcommand per REQ-012; next FETCH.
REQ-019 JUMP: pcWrite=1, pcSrc=1; next FETCH.
REQ-020 HALT: halted=1, all other outputs 0; remains until reset.
REQ-021 memRead and memWrite SHALL never be high in the same cycle; pcWrite SHALL be high at most one cycle per state visit.
REQ-022 Opcode SHALL be latched at DECODE entry; upcode changes after DECODE SHALL not alter the running instruction.
REQ-023 Latency with mem_ready tied 1: LDA/ADD/SUB/AND 4 cycles, STA 3, NOT 3, JMP 3, taken JZ 3, untaken JZ/NOP 2; each wait cycle adds 1.

Reset
REQ-024 rst=0 SHALL force state IDLE and all outputs 0 asynchronously, including mid-wait in MEMRD/MEMWR and in HALT.
REQ-025 After rst rises, the first rising clk edge SHALL move IDLE->FETCH.

Structure
REQ-026 Opcode values, ALU command codes and state encoding SHALL live in shared package acc_ctrl_pkg.
REQ-027 Opcode classification SHALL be one sub-module acc_op_decode (upcode in, class and ALU code out, combinational).
REQ-028 Target size 120-400 lines RTL; no datapath storage other than state and latched opcode.

Verification
REQ-029 mem_ready=1, upcode=2 (ADD) -> IDLE,FETCH(irWrite=1,pcWrite=1),DECODE,MEMRD(memRead=1,memAddressSel=1),WB(ACwrite=1,ACread=1,ALUcommand=0), then FETCH.
REQ-030 upcode=1 (STA), mem_ready low 3 cycles in MEMWR -> memWrite=1 and ACread=1 for 4 cycles, then FETCH, no ACwrite.
REQ-031 upcode=7 with acZero=1 -> JUMP with pcWrite=1,pcSrc=1; with acZero=0 -> DECODE->FETCH, no pcSrc=1.
REQ-032 upcode=10 -> illegal=1 for exactly one cycle in DECODE, next FETCH; upcode=15 -> halted=1 held 20 cycles, no memRead.
REQ-033 rst=0 asserted mid-clock during MEMRD with mem_ready=0 -> outputs 0 immediately; after release, FETCH on first edge.
REQ-034 OPW=6, upcode=6'h22 -> treated illegal; ALUW=5, SUB -> ALUcommand=5'b00001.

Source files
------------

// File: rtl/acc_ctrl_pkg.sv
// Shared encodings for the accumulator multi-cycle controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the FSM state encoding, the 4-bit opcode map, the ALU command
// codes and the opcode class used between the decoder and the FSM.
package acc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_MEMRD  = 3'd3,
        ST_MEMWR  = 3'd4,
        ST_WB     = 3'd5,
        ST_JUMP   = 3'd6,
        ST_HALT   = 3'd7
    } state_e;

    // Opcode map (low nibble; any set bit above the nibble is illegal).
    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_STA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_JMP = 4'd6;
    localparam logic [3:0] OP_JZ  = 4'd7;
    localparam logic [3:0] OP_NOP = 4'd8;
    localparam logic [3:0] OP_HLT = 4'd15;

    localparam int ALU_CMD_W = 3;

    typedef enum logic [ALU_CMD_W-1:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_NOT  = 3'd3,
        ALU_PASS = 3'd4
    } alu_cmd_e;

    // What the FSM needs to know about an opcode to sequence it.
    typedef enum logic [3:0] {
        CLS_LOAD    = 4'd0,  // LDA: memory read, write AC via pass-through
        CLS_STORE   = 4'd1,  // STA: memory write of AC
        CLS_ALU_MEM = 4'd2,  // ADD/SUB/AND: memory operand, ALU result to AC
        CLS_ALU_REG = 4'd3,  // NOT: AC-only ALU op
        CLS_JMP     = 4'd4,
        CLS_JZ      = 4'd5,
        CLS_NOP     = 4'd6,
        CLS_HALT    = 4'd7,
        CLS_ILLEGAL = 4'd8
    } op_class_e;

endpackage

// File: rtl/acc_op_decode.sv
// Opcode classifier: maps an opcode to its sequencing class and ALU command.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input.
//
// Ports:
//   upcode_i  [OPW-1:0]  opcode to classify
//   class_o              sequencing class (CLS_ILLEGAL for unmapped codes)
//   alu_o                ALU command for the write-back of this opcode
module acc_op_decode
    import acc_ctrl_pkg::*;
#(
    parameter int OPW = 4
) (
    input  logic [OPW-1:0] upcode_i,
    output op_class_e      class_o,
    output alu_cmd_e       alu_o
);

    // Any bit above the 4-bit opcode map makes the opcode illegal.
    logic hi_zero;

    generate
        if (OPW > 4) begin : g_wide
            assign hi_zero = ~|upcode_i[OPW-1:4];
        end else begin : g_narrow
            assign hi_zero = 1'b1;
        end
    endgenerate

    always_comb begin
        class_o = CLS_ILLEGAL;
        alu_o   = ALU_PASS;
        if (hi_zero) begin
            case (upcode_i[3:0])
                OP_LDA: class_o = CLS_LOAD;
                OP_STA: class_o = CLS_STORE;
                OP_ADD: begin class_o = CLS_ALU_MEM; alu_o = ALU_ADD; end
                OP_SUB: begin class_o = CLS_ALU_MEM; alu_o = ALU_SUB; end
                OP_AND: begin class_o = CLS_ALU_MEM; alu_o = ALU_AND; end
                OP_NOT: begin class_o = CLS_ALU_REG; alu_o = ALU_NOT; end
                OP_JMP: class_o = CLS_JMP;
                OP_JZ:  class_o = CLS_JZ;
                OP_NOP: class_o = CLS_NOP;
                OP_HLT: class_o = CLS_HALT;
                default: class_o = CLS_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/acc_mc_controller.sv
// Multi-cycle Moore control FSM for a single-accumulator CPU datapath.
// Latency: 2..4 cycles per instruction with mem_ready high, +1 per wait cycle.
// Backpressure: FETCH/MEMRD/MEMWR hold with outputs steady until mem_ready=1.
//
// Ports:
//   clk, rst (async active-low)      clock and reset
//   upcode [OPW-1:0]                 opcode from IR, valid from DECODE on
//   mem_ready, acZero                memory handshake, accumulator-is-zero
//   pcWrite..ACread, ALUcommand      datapath controls
//   halted, illegal                  status (illegal is a one-cycle pulse)
module acc_mc_controller
    import acc_ctrl_pkg::*;
#(
    parameter int OPW  = 4,
    parameter int ALUW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OPW-1:0]  upcode,
    input  logic            mem_ready,
    input  logic            acZero,
    output logic            pcWrite,
    output logic            pcSrc,
    output logic            memAddressSel,
    output logic            ACdataSel,
    output logic            memRead,
    output logic            memWrite,
    output logic            irWrite,
    output logic            ACwrite,
    output logic            ACread,
    output logic [ALUW-1:0] ALUcommand,
    output logic            halted,
    output logic            illegal
);

    state_e               state_q, state_d;
    logic     [OPW-1:0]   op_q, op_d;
    op_class_e            op_cls;
    alu_cmd_e             op_alu;
    alu_cmd_e             alu_cmd;
    logic [ALU_CMD_W-1:0] alu_bits;

    // The IR is loaded on the FETCH->DECODE edge, so the opcode only becomes
    // valid during DECODE. DECODE therefore classifies the live upcode and the
    // same value is captured as DECODE is left; every later state works from
    // the captured copy, so upcode may change freely after DECODE.
    assign op_d = (state_q == ST_DECODE) ? upcode : op_q;

    acc_op_decode #(
        .OPW (OPW)
    ) u_dec (
        .upcode_i (op_d),
        .class_o  (op_cls),
        .alu_o    (op_alu)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pcWrite       = 1'b0;
        pcSrc         = 1'b0;
        memAddressSel = 1'b0;
        ACdataSel     = 1'b0;
        memRead       = 1'b0;
        memWrite      = 1'b0;
        irWrite       = 1'b0;
        ACwrite       = 1'b0;
        ACread        = 1'b0;
        halted        = 1'b0;
        illegal       = 1'b0;
        // IDLE, DECODE and HALT drive every control low, ALU code included;
        // the active states select PASS unless write-back needs a real op.
        alu_cmd       = ALU_ADD;

        case (state_q)
            ST_IDLE: state_d = ST_FETCH;

            ST_FETCH: begin
                memRead = 1'b1;
                alu_cmd = ALU_PASS;
                if (mem_ready) begin
                    irWrite = 1'b1;
                    pcWrite = 1'b1;
                    state_d = ST_DECODE;
                end
            end

            ST_DECODE: begin
                case (op_cls)
                    CLS_LOAD, CLS_ALU_MEM: state_d = ST_MEMRD;
                    CLS_STORE:             state_d = ST_MEMWR;
                    CLS_ALU_REG:           state_d = ST_WB;
                    CLS_JMP:               state_d = ST_JUMP;
                    CLS_JZ:                state_d = acZero ? ST_JUMP : ST_FETCH;
                    CLS_NOP:               state_d = ST_FETCH;
                    CLS_HALT:              state_d = ST_HALT;
                    default: begin
                        illegal = 1'b1;
                        state_d = ST_FETCH;
                    end
                endcase
            end

            ST_MEMRD: begin
                memAddressSel = 1'b1;
                memRead       = 1'b1;
                alu_cmd       = ALU_PASS;
                if (mem_ready) state_d = ST_WB;
            end

            ST_MEMWR: begin
                memAddressSel = 1'b1;
                memWrite      = 1'b1;
                ACread        = 1'b1;
                alu_cmd       = ALU_PASS;
                if (mem_ready) state_d = ST_FETCH;
            end

            ST_WB: begin
                ACwrite = 1'b1;
                state_d = ST_FETCH;
                if (op_cls == CLS_LOAD) begin
                    ACdataSel = 1'b0;
                    alu_cmd   = ALU_PASS;
                end else begin
                    ACdataSel = 1'b1;
                    ACread    = 1'b1;
                    alu_cmd   = op_alu;
                end
            end

            ST_JUMP: begin
                pcWrite = 1'b1;
                pcSrc   = 1'b1;
                alu_cmd = ALU_PASS;
                state_d = ST_FETCH;
            end

            ST_HALT: halted = 1'b1;

            default: state_d = ST_IDLE;
        endcase
    end

    assign alu_bits   = alu_cmd;
    assign ALUcommand = ALUW'(alu_bits);

endmodule
